// File: rtl/fp_pkg.sv
// Shared FP result types: flag bit positions, mode tags and the
// result/flags/mode bundle carried from the ALU through the collector FIFO.
package fp_pkg;

    localparam int FLG_NX = 0;
    localparam int FLG_UF = 1;
    localparam int FLG_OF = 2;
    localparam int FLG_DZ = 3;
    localparam int FLG_NV = 4;
    localparam int FLG_W  = 5;

    localparam logic FP_HALF   = 1'b0;
    localparam logic FP_SINGLE = 1'b1;

    typedef struct packed {
        logic [31:0]      data;
        logic [FLG_W-1:0] flags;
        logic             mode;
    } fp_res_t;

endpackage

// File: rtl/fp_res_fifo.sv
// Generic DEPTH x fp_res_t synchronous FIFO with registered storage and head.
// Ports: clk, rst (async active-low), push_i/wdata_i, pop_i, rdata_o (head),
//        count_o (occupancy), full_o, empty_o. Push while full is only taken
//        when a pop happens in the same cycle; pop on empty is ignored.
module fp_res_fifo
    import fp_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH) + 1,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  fp_res_t          wdata_i,
    input  logic             pop_i,
    output fp_res_t          rdata_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    fp_res_t          mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign pop_ok  = pop_i && !empty_o;
    // A full FIFO still takes a push when the head leaves this same cycle.
    assign push_ok = push_i && (!full_o || pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // DEPTH is a power of two, so pointer overflow is the wrap.
        if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (push_ok && !pop_ok) count_d = count_q + CNT_W'(1);
        if (!push_ok && pop_ok) count_d = count_q - CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/fp_result_collector.sv
// Collects FP ALU results into a small FIFO, formats half results to 32 bits,
// and keeps sticky IEEE exception flags plus a sticky overflow-drop indicator.
// Ports: clk, rst (async active-low); in_valid/in_result/in_flags/in_mode_fp
//        from the ALU; clear_flags; out_ready/out_valid/out_data/out_flags/
//        out_mode_fp to the consumer; sticky_flags, count, drop_err status.
// Build option FP_NANBOX_EN: half results NaN-boxed (upper 16 bits all ones)
// instead of zero-extended.
module fp_result_collector
    import fp_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [31:0]      in_result,
    input  logic [4:0]       in_flags,
    input  logic             in_mode_fp,
    input  logic             clear_flags,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [31:0]      out_data,
    output logic [4:0]       out_flags,
    output logic             out_mode_fp,
    output logic [4:0]       sticky_flags,
    output logic [CNT_W-1:0] count,
    output logic             drop_err
);

`ifdef FP_NANBOX_EN
    localparam logic [15:0] HALF_UPPER = 16'hFFFF;
`else
    localparam logic [15:0] HALF_UPPER = 16'h0000;
`endif

    fp_res_t    wr_ent;
    fp_res_t    head;
    logic       full;
    logic       empty;
    logic       pop;
    logic       drop;
    logic [4:0] sticky_q, sticky_d;
    logic       drop_q, drop_d;

    always_comb begin
        wr_ent.flags = in_flags;
        wr_ent.mode  = in_mode_fp;
        if (in_mode_fp == FP_SINGLE)
            wr_ent.data = in_result;
        else
            wr_ent.data = {HALF_UPPER, in_result[15:0]};
    end

    assign pop  = !empty && out_ready;
    // The ALU cannot be stalled, so a result meeting a full FIFO is lost.
    assign drop = in_valid && full && !pop;

    fp_res_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (in_valid),
        .wdata_i (wr_ent),
        .pop_i   (pop),
        .rdata_o (head),
        .count_o (count),
        .full_o  (full),
        .empty_o (empty)
    );

    always_comb begin
        sticky_d = sticky_q;
        drop_d   = drop_q;
        // New flags take priority over a same-cycle clear.
        if (in_valid && clear_flags) sticky_d = in_flags;
        else if (in_valid)           sticky_d = sticky_q | in_flags;
        else if (clear_flags)        sticky_d = '0;
        if (drop)             drop_d = 1'b1;
        else if (clear_flags) drop_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sticky_q <= '0;
            drop_q   <= 1'b0;
        end else begin
            sticky_q <= sticky_d;
            drop_q   <= drop_d;
        end
    end

    assign out_valid    = !empty;
    assign out_data     = head.data;
    assign out_flags    = head.flags;
    assign out_mode_fp  = head.mode;
    assign sticky_flags = sticky_q;
    assign drop_err     = drop_q;

endmodule

// File: tb/tb_fp_result_collector.sv
// Self-checking bench for fp_result_collector: directed cases plus a
// randomized run against a queue-based reference model.
module tb_fp_result_collector;

    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH) + 1;

`ifdef FP_NANBOX_EN
    localparam logic [15:0] EXP_UPPER = 16'hFFFF;
`else
    localparam logic [15:0] EXP_UPPER = 16'h0000;
`endif

    typedef struct {
        logic [31:0] data;
        logic [4:0]  flags;
        logic        mode;
    } ent_t;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic [31:0]      in_result;
    logic [4:0]       in_flags;
    logic             in_mode_fp;
    logic             clear_flags;
    logic             out_ready;
    logic             out_valid;
    logic [31:0]      out_data;
    logic [4:0]       out_flags;
    logic             out_mode_fp;
    logic [4:0]       sticky_flags;
    logic [CNT_W-1:0] count;
    logic             drop_err;

    int   n_chk;
    int   n_err;
    ent_t mq[$];
    logic [4:0] m_sticky;
    logic       m_drop;

    fp_result_collector #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_result    (in_result),
        .in_flags     (in_flags),
        .in_mode_fp   (in_mode_fp),
        .clear_flags  (clear_flags),
        .out_ready    (out_ready),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_flags    (out_flags),
        .out_mode_fp  (out_mode_fp),
        .sticky_flags (sticky_flags),
        .count        (count),
        .drop_err     (drop_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] fmt(input logic [31:0] r, input logic m);
        return m ? r : {EXP_UPPER, r[15:0]};
    endfunction

    task automatic check_model(input string tag);
        check({tag, ".valid"}, 32'(out_valid), 32'(mq.size() > 0));
        check({tag, ".count"}, 32'(count), 32'(mq.size()));
        check({tag, ".sticky"}, 32'(sticky_flags), 32'(m_sticky));
        check({tag, ".drop"}, 32'(drop_err), 32'(m_drop));
        if (mq.size() > 0) begin
            check({tag, ".data"}, out_data, mq[0].data);
            check({tag, ".flags"}, 32'(out_flags), 32'(mq[0].flags));
            check({tag, ".mode"}, 32'(out_mode_fp), 32'(mq[0].mode));
        end
    endtask

    // Drive one cycle of inputs, advance the model across the edge, compare.
    task automatic step(input logic v, input logic [31:0] r,
                        input logic [4:0] f, input logic m,
                        input logic clr, input logic rdy,
                        input string tag);
        bit   pop_m;
        bit   push_m;
        ent_t e;
        in_valid    = v;
        in_result   = r;
        in_flags    = f;
        in_mode_fp  = m;
        clear_flags = clr;
        out_ready   = rdy;
        @(posedge clk);
        pop_m  = (mq.size() > 0) && rdy;
        push_m = v && ((mq.size() < DEPTH) || pop_m);
        if (pop_m) void'(mq.pop_front());
        if (push_m) begin
            e.data  = fmt(r, m);
            e.flags = f;
            e.mode  = m;
            mq.push_back(e);
        end
        if (v) m_sticky = clr ? f : (m_sticky | f);
        else if (clr) m_sticky = '0;
        if (v && !push_m) m_drop = 1'b1;
        else if (clr) m_drop = 1'b0;
        #1;
        check_model(tag);
    endtask

    task automatic idle(input logic rdy, input string tag);
        step(1'b0, 32'h0, 5'h0, 1'b0, 1'b0, rdy, tag);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #3;
        mq.delete();
        m_sticky = '0;
        m_drop   = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_chk       = 0;
        n_err       = 0;
        m_sticky    = '0;
        m_drop      = 1'b0;
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_result   = '0;
        in_flags    = '0;
        in_mode_fp  = 1'b0;
        clear_flags = 1'b0;
        out_ready   = 1'b0;
        #2;
        do_reset();

        // Reset state
        check("rst.valid", 32'(out_valid), 32'd0);
        check("rst.data", out_data, 32'd0);
        check("rst.flags", 32'(out_flags), 32'd0);
        check("rst.mode", 32'(out_mode_fp), 32'd0);
        check("rst.count", 32'(count), 32'd0);
        check("rst.sticky", 32'(sticky_flags), 32'd0);
        check("rst.drop", 32'(drop_err), 32'd0);

        // 1: single-precision push, visible next cycle, then popped
        step(1'b1, 32'h3F800000, 5'b00000, 1'b1, 1'b0, 1'b1, "t1.push");
        check("t1.data_const", out_data, 32'h3F800000);
        check("t1.cnt1", 32'(count), 32'd1);
        idle(1'b1, "t1.pop");
        check("t1.cnt0", 32'(count), 32'd0);

        // 2: half-precision formatting
        step(1'b1, 32'hABCD3C00, 5'b00000, 1'b0, 1'b0, 1'b0, "t2.push");
        check("t2.half", out_data, {EXP_UPPER, 16'h3C00});
        idle(1'b1, "t2.pop");

        // 3: overflow with five pulses and no pop
        for (int i = 0; i < 5; i++)
            step(1'b1, 32'h1000 + 32'(i), 5'(i), 1'b1, 1'b0, 1'b0, "t3.fill");
        check("t3.full", 32'(count), 32'd4);
        check("t3.drop", 32'(drop_err), 32'd1);
        check("t3.head", out_data, 32'h1000);
        for (int i = 0; i < 4; i++) idle(1'b1, "t3.drain");
        idle(1'b1, "t3.empty");
        check("t3.none", 32'(out_valid), 32'd0);
        for (int i = 0; i < 4; i++)
            step(1'b1, 32'h2000 + 32'(i), 5'h0, 1'b1, 1'b0, 1'b0, "t3.refill");
        step(1'b1, 32'h2004, 5'h0, 1'b1, 1'b0, 1'b1, "t3.pushpop");
        check("t3.stay4", 32'(count), 32'd4);
        check("t3.newhead", out_data, 32'h2001);
        for (int i = 0; i < 5; i++) idle(1'b1, "t3.drain2");
        step(1'b0, 32'h0, 5'h0, 1'b0, 1'b1, 1'b1, "t3.clr");
        check("t3.dropclr", 32'(drop_err), 32'd0);

        // 4: sticky flag accumulation and clear-vs-new priority
        step(1'b1, 32'h1, 5'b00001, 1'b1, 1'b0, 1'b1, "t4.f1");
        step(1'b1, 32'h2, 5'b01000, 1'b1, 1'b0, 1'b1, "t4.f2");
        check("t4.acc", 32'(sticky_flags), 32'b01001);
        step(1'b1, 32'h3, 5'b00100, 1'b1, 1'b1, 1'b1, "t4.clrnew");
        check("t4.win", 32'(sticky_flags), 32'b00100);
        for (int i = 0; i < 2; i++) idle(1'b1, "t4.drain");

        // 5: asynchronous reset with entries queued
        for (int i = 0; i < 3; i++)
            step(1'b1, 32'h5000 + 32'(i), 5'b10000, 1'b1, 1'b0, 1'b0, "t5.fill");
        check("t5.cnt3", 32'(count), 32'd3);
        rst = 1'b0;
        #1;
        check("t5.valid", 32'(out_valid), 32'd0);
        check("t5.data", out_data, 32'd0);
        check("t5.count", 32'(count), 32'd0);
        check("t5.sticky", 32'(sticky_flags), 32'd0);
        check("t5.flags", 32'(out_flags), 32'd0);
        in_valid = 1'b0;
        do_reset();
        step(1'b1, 32'h7777, 5'b00010, 1'b0, 1'b0, 1'b0, "t5.after");
        check("t5.after_cnt", 32'(count), 32'd1);
        idle(1'b1, "t5.pop");

        // 6: randomized traffic against the queue model
        for (int c = 0; c < 10000; c++) begin
            step($urandom_range(0, 99) < 60, $urandom(), 5'($urandom()),
                 1'($urandom()), $urandom_range(0, 31) == 0,
                 $urandom_range(0, 99) < 45, "rand");
        end
        for (int i = 0; i < DEPTH + 1; i++) idle(1'b1, "final");
        check("final.empty", 32'(count), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
